// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between two cache requesters, the memory arbiter and main memory.
// The arbiter takes the slave view; requesters/memory (or a bench) take the master view.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              req_valid_0, req_valid_1;
    logic              req_ready_0, req_ready_1;
    logic              req_wr_0, req_wr_1;
    logic [ADDR_W-1:0] req_addr_0, req_addr_1;
    logic [31:0]       req_wdata_0, req_wdata_1;
    logic              rsp_valid_0, rsp_valid_1;
    logic [LINE_W-1:0] rsp_line;
    logic [31:0]       rsp_word;
    logic              rsp_err;
    logic              mem_valid, mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_line;
    logic [31:0]       mem_word;

    modport slave (
        input  req_valid_0, req_valid_1, req_wr_0, req_wr_1,
        input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        output req_ready_0, req_ready_1,
        output rsp_valid_0, rsp_valid_1, rsp_line, rsp_word, rsp_err,
        output mem_valid, mem_wr_en, mem_addr, mem_wdata,
        input  mem_ready, mem_line, mem_word
    );

    modport master (
        output req_valid_0, req_valid_1, req_wr_0, req_wr_1,
        output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        input  req_ready_0, req_ready_1,
        input  rsp_valid_0, rsp_valid_1, rsp_line, rsp_word, rsp_err,
        input  mem_valid, mem_wr_en, mem_addr, mem_wdata,
        output mem_ready, mem_line, mem_word
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-ported main memory:
// one operation in flight, read watchdog that terminates with an error.
module mem_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic              gnt;
    logic              accept;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        word_d  = word_q;
        err_d   = err_q;

        // On a tie the port that did not win last time goes; otherwise the lone requester.
        gnt    = (bus.req_valid_0 & bus.req_valid_1) ? ~last_q : ~bus.req_valid_0;
        accept = (state_q == IDLE) & (bus.req_valid_0 | bus.req_valid_1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = gnt;
                    last_d  = gnt;
                    wr_d    = gnt ? bus.req_wr_1    : bus.req_wr_0;
                    addr_d  = gnt ? bus.req_addr_1  : bus.req_addr_0;
                    wdata_d = gnt ? bus.req_wdata_1 : bus.req_wdata_0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (wr_q) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    line_d  = bus.mem_line;
                    word_d  = bus.mem_word;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    line_d  = '0;
                    word_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    assign bus.req_ready_0 = rst_n & accept & ~gnt;
    assign bus.req_ready_1 = rst_n & accept & gnt;
    assign bus.mem_valid   = (state_q == ISSUE) & ~wr_q;
    assign bus.mem_wr_en   = (state_q == ISSUE) & wr_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.rsp_valid_0 = (state_q == RESP) & ~owner_q;
    assign bus.rsp_valid_1 = (state_q == RESP) & owner_q;
    assign bus.rsp_line    = line_q;
    assign bus.rsp_word    = word_q;
    assign bus.rsp_err     = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: transaction-level model predicts grants,
// strobe cycles and response latency/contents each cycle.
module tb_mem_req_arbiter;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 256;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;

    mem_req_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_req_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c;
        int p;
        bit err;
    } ev_t;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // requester side
    bit          p_vld[2];
    bit          p_wr[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wdata[2];
    int          req_pct;
    bit          wr_rand;

    // memory behaviour knobs
    int lat_knob;
    bit force_to;
    bit stray_en;

    // transaction-level reference
    bit           m_busy, m_wr, m_owner, m_last, m_to;
    int           m_acc, m_rsp, m_rdy;
    logic [31:0]  e_maddr, e_mwdata, e_word, cap_word;
    logic [255:0] e_line, cap_line;
    bit           e_err;

    ev_t acc_log[$];
    ev_t rsp_log[$];

    task automatic model_reset();
        m_busy = 0; m_wr = 0; m_owner = 0; m_last = 1; m_to = 0;
        m_acc = -100; m_rsp = -100; m_rdy = -100;
        e_maddr = '0; e_mwdata = '0; e_line = '0; e_word = '0; e_err = 0;
    endtask

    task automatic clear_inputs();
        p_vld[0] = 0; p_vld[1] = 0;
        bus.req_valid_0 = 0; bus.req_valid_1 = 0;
        bus.req_wr_0 = 0; bus.req_wr_1 = 0;
        bus.req_addr_0 = '0; bus.req_addr_1 = '0;
        bus.req_wdata_0 = '0; bus.req_wdata_1 = '0;
        bus.mem_ready = 0; bus.mem_line = '0; bus.mem_word = '0;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic tick();
        bit in_wait, gv, g, er0, er1, emv, ewr, ers0, ers1;
        logic [255:0] ln;
        int lat;
        in_wait = m_busy && !m_wr && cyc >= m_acc + 2 && cyc < m_rsp;
        bus.req_valid_0 = p_vld[0]; bus.req_valid_1 = p_vld[1];
        bus.req_wr_0 = p_wr[0];     bus.req_wr_1 = p_wr[1];
        bus.req_addr_0 = p_addr[0]; bus.req_addr_1 = p_addr[1];
        bus.req_wdata_0 = p_wdata[0]; bus.req_wdata_1 = p_wdata[1];
        for (int k = 0; k < 8; k++) ln[k*32 +: 32] = $urandom;
        bus.mem_line = ln;
        bus.mem_word = $urandom;
        bus.mem_ready = (m_busy && !m_wr && !m_to && cyc == m_rdy) ||
                        (stray_en && !in_wait && $urandom_range(0, 3) == 0);
        #1;

        // round robin from the rules: tie -> the port not granted last, else the lone one
        gv = !m_busy && (p_vld[0] || p_vld[1]);
        if (p_vld[0] && p_vld[1]) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
        else                      g = p_vld[1];
        er0 = gv && (g == 1'b0);
        er1 = gv && (g == 1'b1);

        vectors++;
        if (bus.req_ready_0 !== er0) begin
            miscompares++;
            $display("FAIL req_ready_0 cyc=%0d got=%b exp=%b", cyc, bus.req_ready_0, er0);
        end
        vectors++;
        if (bus.req_ready_1 !== er1) begin
            miscompares++;
            $display("FAIL req_ready_1 cyc=%0d got=%b exp=%b", cyc, bus.req_ready_1, er1);
        end
        if (bus.req_ready_0 === 1'b1) acc_log.push_back('{cyc, 0, 1'b0});
        if (bus.req_ready_1 === 1'b1) acc_log.push_back('{cyc, 1, 1'b0});

        emv = m_busy && cyc == m_acc + 1 && !m_wr;
        ewr = m_busy && cyc == m_acc + 1 && m_wr;
        vectors++;
        if (bus.mem_valid !== emv) begin
            miscompares++;
            $display("FAIL mem_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_valid, emv);
        end
        vectors++;
        if (bus.mem_wr_en !== ewr) begin
            miscompares++;
            $display("FAIL mem_wr_en cyc=%0d got=%b exp=%b", cyc, bus.mem_wr_en, ewr);
        end
        vectors++;
        if (bus.mem_addr !== e_maddr || bus.mem_wdata !== e_mwdata) begin
            miscompares++;
            $display("FAIL mem_addr/wdata cyc=%0d got=%h/%h exp=%h/%h",
                     cyc, bus.mem_addr, bus.mem_wdata, e_maddr, e_mwdata);
        end

        if (m_busy && cyc == m_rsp) begin
            if (m_wr) e_err = 0;
            else if (m_to) begin e_line = '0; e_word = '0; e_err = 1; end
            else begin e_line = cap_line; e_word = cap_word; e_err = 0; end
        end
        ers0 = m_busy && cyc == m_rsp && m_owner == 1'b0;
        ers1 = m_busy && cyc == m_rsp && m_owner == 1'b1;
        vectors++;
        if (bus.rsp_valid_0 !== ers0 || bus.rsp_valid_1 !== ers1) begin
            miscompares++;
            $display("FAIL rsp_valid cyc=%0d got=%b%b exp=%b%b",
                     cyc, bus.rsp_valid_1, bus.rsp_valid_0, ers1, ers0);
        end
        vectors++;
        if (bus.rsp_line !== e_line || bus.rsp_word !== e_word || bus.rsp_err !== e_err) begin
            miscompares++;
            $display("FAIL rsp_data cyc=%0d got=%h/%h/%b exp=%h/%h/%b",
                     cyc, bus.rsp_line, bus.rsp_word, bus.rsp_err, e_line, e_word, e_err);
        end
        if (bus.rsp_valid_0 === 1'b1) rsp_log.push_back('{cyc, 0, bus.rsp_err});
        if (bus.rsp_valid_1 === 1'b1) rsp_log.push_back('{cyc, 1, bus.rsp_err});

        if (m_busy && !m_wr && !m_to && cyc == m_rdy) begin
            cap_line = bus.mem_line;
            cap_word = bus.mem_word;
        end

        if (m_busy && cyc == m_rsp) begin
            m_busy = 0;
        end else if (gv) begin
            m_busy = 1; m_owner = g; m_wr = p_wr[g]; m_last = g; m_acc = cyc; m_to = 0;
            e_maddr = p_addr[g]; e_mwdata = p_wdata[g];
            p_vld[g] = 0;
            if (m_wr) begin
                m_rsp = cyc + 2; m_rdy = -100;
            end else if (force_to) begin
                m_to = 1; m_rdy = -100; m_rsp = cyc + 2 + TIMEOUT;
            end else begin
                lat = (lat_knob > 0) ? lat_knob : $urandom_range(1, TIMEOUT);
                m_rdy = cyc + 1 + lat;
                m_rsp = cyc + 2 + lat;
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (!p_vld[p] && $urandom_range(0, 99) < req_pct) begin
                p_vld[p] = 1;
                p_wr[p] = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
                p_addr[p] = $urandom;
                p_wdata[p] = $urandom;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        cyc++;
    endtask

    task automatic drain();
        req_pct = 0;
        for (int i = 0; i < 80 && (m_busy || p_vld[0] || p_vld[1]); i++) tick();
        vectors++;
        if (m_busy || p_vld[0] || p_vld[1]) begin
            miscompares++;
            $display("FAIL drain_timeout busy=%b pending=%b%b", m_busy, p_vld[1], p_vld[0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1;
        clear_inputs();
        #1 rst_n = 0;
        bus.req_valid_0 = 1; bus.req_valid_1 = 1;
        #2;
        vectors++;
        if (bus.req_ready_0 !== 1'b0 || bus.req_ready_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got=%b%b exp=00", bus.req_ready_1, bus.req_ready_0);
        end
        vectors++;
        if (bus.mem_valid !== 1'b0 || bus.mem_wr_en !== 1'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mem got=%b%b %h %h exp=00 0 0",
                     bus.mem_valid, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata);
        end
        vectors++;
        if (bus.rsp_valid_0 !== 1'b0 || bus.rsp_valid_1 !== 1'b0 || bus.rsp_line !== '0 ||
            bus.rsp_word !== '0 || bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp got=%b%b %h %h %b exp=all zero",
                     bus.rsp_valid_1, bus.rsp_valid_0, bus.rsp_line, bus.rsp_word, bus.rsp_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_inputs();
        model_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        acc_log.delete(); rsp_log.delete();
        lat_knob = 1; force_to = 0; stray_en = 0; req_pct = 0;
        p_vld[0] = 1; p_wr[0] = 0; p_addr[0] = 32'h40; p_wdata[0] = 32'h0;
        repeat (6) tick();
        vectors++;
        if (acc_log.size() != 1 || rsp_log.size() != 1) begin
            miscompares++;
            $display("FAIL single_read_counts got=%0d/%0d exp=1/1", acc_log.size(), rsp_log.size());
        end else begin
            vectors++;
            if (rsp_log[0].p != 0 || rsp_log[0].c - acc_log[0].c != 3 || rsp_log[0].err) begin
                miscompares++;
                $display("FAIL single_read_rsp got=port%0d lat%0d err%b exp=port0 lat3 err0",
                         rsp_log[0].p, rsp_log[0].c - acc_log[0].c, rsp_log[0].err);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        acc_log.delete(); rsp_log.delete();
        lat_knob = 1; req_pct = 0;
        p_vld[0] = 1; p_wr[0] = 0; p_addr[0] = 32'h100; p_wdata[0] = '0;
        p_vld[1] = 1; p_wr[1] = 0; p_addr[1] = 32'h200; p_wdata[1] = '0;
        repeat (10) tick();
        vectors++;
        if (acc_log.size() != 2 || rsp_log.size() != 2) begin
            miscompares++;
            $display("FAIL simul_counts got=%0d/%0d exp=2/2", acc_log.size(), rsp_log.size());
        end else begin
            vectors++;
            if (acc_log[0].p != 0 || acc_log[1].p != 1 || acc_log[1].c - acc_log[0].c != 4) begin
                miscompares++;
                $display("FAIL simul_order got=%0d,%0d gap%0d exp=0,1 gap4",
                         acc_log[0].p, acc_log[1].p, acc_log[1].c - acc_log[0].c);
            end
            vectors++;
            if (rsp_log[0].p != 0 || rsp_log[1].p != 1) begin
                miscompares++;
                $display("FAIL simul_rsp_order got=%0d,%0d exp=0,1", rsp_log[0].p, rsp_log[1].p);
            end
        end
    endtask

    task automatic test_contention();
        int exp_p;
        acc_log.delete(); rsp_log.delete();
        lat_knob = 0; wr_rand = 1; req_pct = 100;
        for (int i = 0; i < 120 && acc_log.size() < 6; i++) tick();
        vectors++;
        if (acc_log.size() < 6) begin
            miscompares++;
            $display("FAIL contention_count got=%0d exp>=6", acc_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_p = i % 2;
                vectors++;
                if (acc_log[i].p != exp_p) begin
                    miscompares++;
                    $display("FAIL contention_grant%0d got=%0d exp=%0d", i, acc_log[i].p, exp_p);
                end
            end
        end
        wr_rand = 0;
        drain();
    endtask

    task automatic test_write();
        acc_log.delete(); rsp_log.delete();
        req_pct = 0;
        p_vld[1] = 1; p_wr[1] = 1; p_addr[1] = 32'h8; p_wdata[1] = 32'hDEADBEEF;
        repeat (5) tick();
        vectors++;
        if (acc_log.size() != 1 || rsp_log.size() != 1) begin
            miscompares++;
            $display("FAIL write_counts got=%0d/%0d exp=1/1", acc_log.size(), rsp_log.size());
        end else begin
            vectors++;
            if (rsp_log[0].p != 1 || rsp_log[0].c - acc_log[0].c != 2 || rsp_log[0].err) begin
                miscompares++;
                $display("FAIL write_rsp got=port%0d lat%0d err%b exp=port1 lat2 err0",
                         rsp_log[0].p, rsp_log[0].c - acc_log[0].c, rsp_log[0].err);
            end
        end
    endtask

    task automatic test_timeout();
        acc_log.delete(); rsp_log.delete();
        req_pct = 0; force_to = 1; stray_en = 1;
        p_vld[0] = 1; p_wr[0] = 0; p_addr[0] = $urandom; p_wdata[0] = '0;
        for (int i = 0; i < 40 && rsp_log.size() == 0; i++) tick();
        force_to = 0; lat_knob = 2;
        p_vld[1] = 1; p_wr[1] = 0; p_addr[1] = $urandom; p_wdata[1] = '0;
        repeat (8) tick();
        vectors++;
        if (acc_log.size() != 2 || rsp_log.size() != 2) begin
            miscompares++;
            $display("FAIL timeout_counts got=%0d/%0d exp=2/2", acc_log.size(), rsp_log.size());
        end else begin
            vectors++;
            if (rsp_log[0].c - acc_log[0].c != 17 || !rsp_log[0].err) begin
                miscompares++;
                $display("FAIL timeout_rsp got=lat%0d err%b exp=lat17 err1",
                         rsp_log[0].c - acc_log[0].c, rsp_log[0].err);
            end
            vectors++;
            if (rsp_log[1].p != 1 || rsp_log[1].c - acc_log[1].c != 4 || rsp_log[1].err) begin
                miscompares++;
                $display("FAIL after_timeout got=port%0d lat%0d err%b exp=port1 lat4 err0",
                         rsp_log[1].p, rsp_log[1].c - acc_log[1].c, rsp_log[1].err);
            end
        end
        stray_en = 0; lat_knob = 0;
        drain();
    endtask

    task automatic test_reset_mid_read();
        req_pct = 0; force_to = 1; stray_en = 0;
        p_vld[0] = 1; p_wr[0] = 0; p_addr[0] = 32'h1234_5670; p_wdata[0] = 32'h55;
        repeat (5) tick();
        rst_n = 0;
        bus.req_valid_0 = 1; bus.req_valid_1 = 1;
        #1;
        vectors++;
        if (bus.mem_valid !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_addr !== '0 ||
            bus.rsp_valid_0 !== 1'b0 || bus.rsp_valid_1 !== 1'b0 ||
            bus.req_ready_0 !== 1'b0 || bus.req_ready_1 !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs got mv=%b we=%b addr=%h rv=%b%b rr=%b%b exp=all zero",
                     bus.mem_valid, bus.mem_wr_en, bus.mem_addr, bus.rsp_valid_1,
                     bus.rsp_valid_0, bus.req_ready_1, bus.req_ready_0);
        end
        vectors++;
        if (bus.rsp_line !== '0 || bus.rsp_word !== '0 || bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_rsp got=%h/%h/%b exp=0/0/0", bus.rsp_line, bus.rsp_word, bus.rsp_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        cyc++;
        force_to = 0; lat_knob = 1;
        acc_log.delete(); rsp_log.delete();
        p_vld[0] = 1; p_wr[0] = 0; p_addr[0] = 32'h80; p_wdata[0] = '0;
        p_vld[1] = 1; p_wr[1] = 1; p_addr[1] = 32'h84; p_wdata[1] = 32'hA5A5_0001;
        repeat (9) tick();
        vectors++;
        if (acc_log.size() < 1 || acc_log[0].p != 0) begin
            miscompares++;
            $display("FAIL midreset_first_tie got_count=%0d exp=port0 first", acc_log.size());
        end
        lat_knob = 0;
        drain();
    endtask

    task automatic test_random();
        lat_knob = 0; force_to = 0; stray_en = 1; wr_rand = 1; req_pct = 30;
        repeat (1500) tick();
        stray_en = 0;
        drain();
    endtask

    initial begin
        p_wr[0] = 0; p_wr[1] = 0;
        p_addr[0] = '0; p_addr[1] = '0;
        p_wdata[0] = '0; p_wdata[1] = '0;
        cap_line = '0; cap_word = '0;
        lat_knob = 0; force_to = 0; stray_en = 0; req_pct = 0; wr_rand = 0;
        model_reset();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_contention();
        test_write();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-port round-robin arbiter and sequencer in front of the single-ported main memory. It accepts line-fill reads and word writes from two requesters, typically instruction-cache fill and data-cache fill/write-through. It issues one memory operation at a time, waits for the memory's registered ready/line response, and returns the response to the owning requester. A watchdog counter terminates reads that never receive ready and flags them with an error.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 256, line width returned by memory (32 bytes)
- `TIMEOUT`, 15, max WAIT cycles before error termination (1..255)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid_0`, `req_valid_1`  in  1  request present; held until accepted
- `req_ready_0`, `req_ready_1`  out  1  request accepted this cycle (combinational)
- `req_wr_0`, `req_wr_1`  in  1  1 = word write, 0 = line read
- `req_addr_0`, `req_addr_1`  in  ADDR_W  byte address
- `req_wdata_0`, `req_wdata_1`  in  32  write data
- `rsp_valid_0`, `rsp_valid_1`  out  1  one-cycle completion pulse to owner
- `rsp_line`  out  LINE_W  captured line (shared, qualified by rsp_valid_x)
- `rsp_word`  out  32  captured word
- `rsp_err`  out  1  timeout on this completion
- `mem_valid`  out  1  read strobe to memory
- `mem_wr_en`  out  1  write strobe to memory
- `mem_addr`  out  ADDR_W  address to memory
- `mem_wdata`  out  32  write data to memory
- `mem_ready`  in  1  memory read acknowledge
- `mem_line`  in  LINE_W  memory line data
- `mem_word`  in  32  memory word data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is computed from `req_valid_x` and `last_grant`.
  - If both ports are valid, the port not equal to `last_grant` wins. Otherwise the single valid port wins.
  - The winner sees `req_ready_x`=1 in the same cycle. The loser sees 0.
  - On the accept edge the block registers `owner`, `wr`, `mem_addr`, and `mem_wdata`, updates `last_grant`=owner, and moves to ISSUE.
- ISSUE (exactly 1 cycle):
  - `mem_valid`=!wr and `mem_wr_en`=wr.
  - Next state: read goes to WAIT with the counter cleared; write goes to RESP.
- WAIT:
  - `mem_valid`=0 and `mem_wr_en`=0.
  - If `mem_ready`=1: capture `mem_line` and `mem_word`, set err=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: set `rsp_line`=0, `rsp_word`=0, err=1, go to RESP.
  - Else increment the counter (8-bit, saturating never reached).
- RESP (exactly 1 cycle):
  - `rsp_valid_owner`=1 and `rsp_err`=err.
  - Next state is IDLE.
  - For a write, `rsp_line` and `rsp_word` keep their previous values and `rsp_err`=0.
- `mem_addr` and `mem_wdata` are held stable from ISSUE through RESP, and also in IDLE until the next accept.
- `req_ready_x` is 0 in every state except IDLE. No new request is accepted while a transaction is in flight.
- `mem_ready` seen outside WAIT is ignored. A stray ready in IDLE or RESP causes no capture.
- `rsp_line`, `rsp_word`, and `rsp_err` are registered and hold until the next capture.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - state=IDLE, `last_grant`=1 (so port 0 wins the first tie).
  - `mem_valid`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0.
  - `rsp_valid_0`/`rsp_valid_1`=0, `rsp_line`=0, `rsp_word`=0, `rsp_err`=0, counter=0.
- `req_ready_x` is 0 during reset.
- Read against memory with 1-cycle registered ready:
  - Accept at cycle T, `mem_valid` at T+1, `mem_ready` sampled at T+2, `rsp_valid` at T+3.
  - Next accept is possible at T+4.
- Write: accept at T, `mem_wr_en` at T+1, `rsp_valid` at T+2, next accept at T+3.
- Timeout read: WAIT lasts TIMEOUT cycles and `rsp_valid` comes at T+2+TIMEOUT.
- Reset asserted mid-transaction: the in-flight operation is dropped, no `rsp_valid` is produced, and strobes drop immediately.
- Both requesters valid continuously: grants strictly alternate, with no starvation.

## Test plan
- Reset then single read: port 0, addr 0x40, memory returns ready one cycle after `mem_valid`.
  - Required: `req_ready_0` at T, `mem_valid`=1 only at T+1 with `mem_addr`=0x40.
  - Required: `rsp_valid_0` at T+3 with `rsp_line`=`mem_line`, `rsp_err`=0, and `rsp_valid_1` never set.
- Simultaneous requests from reset: port 0 read 0x100, port 1 read 0x200, both held.
  - Required: port 0 is served first, then port 1; accepts 4 cycles apart; `rsp_valid_0` then `rsp_valid_1`.
- Continuous contention for 6 transactions: grant order must be 0,1,0,1,0,1.
- Write from port 1: addr 0x8, wdata 0xDEADBEEF.
  - Required: `mem_wr_en`=1 for exactly one cycle with `mem_addr`=0x8 and `mem_wdata`=0xDEADBEEF, `mem_valid`=0.
  - Required: `rsp_valid_1` two cycles after accept with `rsp_err`=0.
- Timeout with TIMEOUT=15: memory never asserts ready.
  - Required: `rsp_valid` 17 cycles after accept with `rsp_err`=1 and `rsp_line`=0.
  - Required: the next request then proceeds normally, and a stray late `mem_ready` causes no capture.
- Reset mid-read: `rst_n` dropped during WAIT.
  - Required: all outputs go to reset values at once, no `rsp_valid` appears, and the first post-reset tie is granted to port 0.
